gather_inject_sched: RTL
========================

// Module: gather_inject_sched
// PURPOSE
//  Shares one FC (gather) start port among NREQ local packet sources. Grants whole packets
//  round-robin, and only when the gather credit counter shows room for a full packet.
//  Generates flit type (HEAD/BODY/TAIL) and the fire strobe that drive the credit counter.
//  Sits between the tile's gather sources and the router local input port.
// PARAMETERS
//  NREQ    4   number of local requesters, >=2
//  FCpl    16  FC packet length in flits incl. head and tail, >=2
//  FLIT_W  32  flit payload width
// PORTS
//  clk            in   1             clock
//  rst            in   1             asynchronous reset, active-high
//  src_valid      in   NREQ          per-source flit valid; a rising/held valid is a packet request
//  src_data       in   NREQ*FLIT_W   per-source flit payload, source i at [i*FLIT_W +: FLIT_W]
//  src_ready      out  NREQ          per-source flit accept
//  credit_cnt     in   32            from gather credit counter; 32'hFFFF_FFFF = non-FC (unlimited)
//  out_valid      out  1             flit valid to router
//  out_data       out  FLIT_W        flit payload to router
//  out_flit_type  out  2             `HEAD/`BODY/`TAIL (params.svh encoding)
//  out_ready      in   1             router accepts flit
//  fire           out  1             out_valid & out_ready; to credit counter
//  grant          out  NREQ          one-hot owner of current packet, 0 when idle
//  credit_stall   out  32            stall statistic (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE, grant=0, rr_ptr=0, flit_idx=0, out_valid=0, src_ready=0, credit_stall=0.
//  - credit_ok = (credit_cnt==32'hFFFF_FFFF) | ($signed(credit_cnt) >= FCpl-2).
//  - IDLE:
//    - If |src_valid & credit_ok: pick the first set bit at or after rr_ptr (wrapping).
//    - Register grant, flit_idx=0, go SEND. No flit moves in the grant cycle (1-cycle latency).
//  - If credit is not ok: stay IDLE, grant=0. Requests are held by the sources, never dropped.
//  - SEND, granted source g:
//    - out_valid = src_valid[g]; src_ready[g] = out_ready; other src_ready = 0.
//    - out_data = src_data[g]; combinational mux, no buffering.
//  - Flit type:
//    - `HEAD when flit_idx==0.
//    - `TAIL when flit_idx==FCpl-1.
//    - `BODY otherwise.
//    - out_flit_type is valid whenever out_valid=1, and holds `HEAD in IDLE.
//  - On fire: flit_idx++. On tail fire: grant=0, rr_ptr=(g+1)%NREQ, go IDLE next cycle.
//  - Source bubbles mid-packet (src_valid[g]=0):
//    - out_valid=0 and the grant is kept.
//    - Packets are never interleaved or aborted.
//  - Router backpressure (out_ready=0): hold flit_idx; src_ready[g]=0.
//  - The credit counter debits on HEAD fire one edge later.
//    - The next credit_ok check happens earliest in the IDLE cycle after tail fire, so it always
//      sees the debit, including at FCpl=2.
//  - credit_cnt may rise (credit return) in any cycle. It is sampled only in IDLE.
//  - Reset mid-packet: immediate return to IDLE (async). A partial packet is system-level
//    reset only; no recovery is attempted.
//  - flit_idx width = $clog2(FCpl); rr_ptr width = $clog2(NREQ). No wrap beyond FCpl-1.
// CONFIGURATION
//  - GATHER_INJ_STALL_STATS_EN defined:
//    - credit_stall is a 32-bit saturating counter (sticks at 32'hFFFF_FFFF).
//    - It increments each cycle with state==IDLE & |src_valid & ~credit_ok.
//    - It clears only on rst.
//  - GATHER_INJ_STALL_STATS_EN undefined: credit_stall tied to 0; no counter logic.
// TESTING
//  1. credit_cnt=14, FCpl=16, src_valid[1]=1, out_ready=1:
//     -> grant=4'b0010 next cycle; 16 fires HEAD,14xBODY,TAIL; fire=1 each cycle; then IDLE.
//  2. credit_cnt=13, src_valid[0]=1:
//     -> grant stays 0, out_valid=0.
//     -> Raise credit_cnt to 14: grant in the next cycle.
//     -> With STATS_EN, credit_stall = number of blocked cycles.
//  3. All 4 sources valid, credit_cnt=32'hFFFF_FFFF:
//     -> grants 0,1,2,3,0 in order; each packet contiguous; credit never checked.
//  4. out_ready toggling 1,0,1 and src_valid[g] dropping for 3 cycles mid-packet:
//     -> no flit lost or duplicated; grant unchanged; flit_idx held.
//  5. FCpl=2, credit_cnt=0, counter model debits on HEAD:
//     -> first packet starts; second request waits until the modelled credit is restored to >=0.
//  6. Assert rst at flit 5 of a packet:
//     -> out_valid, grant, src_ready=0 asynchronously.
//     -> After release, the new packet starts with `HEAD from rr_ptr=0.

Source files
------------

// File: rtl/gather_inject_sched.sv
// rtl/gather_inject_sched.sv - round-robin whole-packet gather injection scheduler with credit gating; optional stall counter under GATHER_INJ_STALL_STATS_EN
module gather_inject_sched #(
    parameter int NREQ   = 4,
    parameter int FCPL   = 16,
    parameter int FLIT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        src_valid_i,
    input  logic [NREQ*FLIT_W-1:0] src_data_i,
    output logic [NREQ-1:0]        src_ready_o,
    input  logic [31:0]            credit_cnt_i,
    output logic                   out_valid_o,
    output logic [FLIT_W-1:0]      out_data_o,
    output logic [1:0]             out_flit_type_o,
    input  logic                   out_ready_i,
    output logic                   fire_o,
    output logic [NREQ-1:0]        grant_o,
    output logic [31:0]            credit_stall_o
);
    localparam logic [1:0] FT_BODY = 2'b00;
    localparam logic [1:0] FT_HEAD = 2'b01;
    localparam logic [1:0] FT_TAIL = 2'b10;

    localparam int IDX_W = $clog2(FCPL);
    localparam int PTR_W = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FCPL - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NREQ - 1);
    // A packet needs FCPL-2 credits beyond the head/tail pair to be admitted.
    localparam logic signed [31:0] CREDIT_NEED = 32'(FCPL - 2);

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] flit_idx_q, flit_idx_d;

    logic             req_any;
    logic             credit_ok;
    logic             pick_found;
    logic [PTR_W-1:0] pick_idx;
    int               cand;

    assign req_any   = |src_valid_i;
    // All-ones is the non-flow-controlled marker and always admits.
    assign credit_ok = (credit_cnt_i == 32'hFFFF_FFFF) ||
                       ($signed(credit_cnt_i) >= CREDIT_NEED);

    // Round-robin search: first requesting source at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NREQ;
            if (!pick_found && src_valid_i[PTR_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'(cand);
            end
        end
    end

    // Next-state and datapath: grant whole packets, steer the owner's flits, tag flit type.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        flit_idx_d      = flit_idx_q;
        out_valid_o     = 1'b0;
        out_data_o      = '0;
        src_ready_o     = '0;
        grant_o         = '0;
        out_flit_type_o = FT_HEAD;
        fire_o          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Grant cycle moves no flit; the owner starts sending next cycle.
                if (req_any && credit_ok) begin
                    state_d    = ST_SEND;
                    owner_d    = pick_idx;
                    flit_idx_d = '0;
                end
            end
            ST_SEND: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (owner_q == PTR_W'(i)) begin
                        grant_o[i]     = 1'b1;
                        src_ready_o[i] = out_ready_i;
                        out_valid_o    = src_valid_i[i];
                        out_data_o     = src_data_i[i*FLIT_W +: FLIT_W];
                    end
                end
                if (flit_idx_q == LAST_IDX) begin
                    out_flit_type_o = FT_TAIL;
                end else if (flit_idx_q != '0) begin
                    out_flit_type_o = FT_BODY;
                end
                fire_o = out_valid_o && out_ready_i;
                if (fire_o) begin
                    if (flit_idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        flit_idx_d = '0;
                        rr_ptr_d   = (owner_q == LAST_PTR) ? '0 : owner_q + 1'b1;
                    end else begin
                        flit_idx_d = flit_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset drops any partial packet immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            flit_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            flit_idx_q <= flit_idx_d;
        end
    end

`ifdef GATHER_INJ_STALL_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Count idle cycles in which a request is held back by credit, saturating.
    always_comb begin
        stall_d = stall_q;
        if (state_q == ST_IDLE && req_any && !credit_ok && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign credit_stall_o = stall_q;
`else
    assign credit_stall_o = '0;
`endif

endmodule
